// File: rtl/neuron_mac_seq.sv
// Sequential neuron evaluator: fetches bias then N weight/pixel pairs from
// single-cycle-latency memories, accumulates the signed dot product, hands it off.
module neuron_mac_seq #(
    parameter int unsigned MAX_FANIN = 400,
    parameter int unsigned ACC_W     = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [8:0]              fan_in,
    output logic                    busy,
    output logic                    err,
    output logic                    mem_rd,
    output logic [8:0]              w_addr,
    output logic [8:0]              x_addr,
    input  logic [8:0]              w_data,
    input  logic [7:0]              x_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] result
);

    localparam int unsigned AW = 9;
    localparam int unsigned PW = 18;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BIAS  = 3'd1,
        MAC   = 3'd2,
        DRAIN = 3'd3,
        OUT   = 3'd4
    } state_t;

    state_t          state, state_d;
    logic [AW-1:0]   n_q, n_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            fan_ok;
    logic            err_d, busy_d, mem_rd_d, out_valid_d;
    logic [AW-1:0]   w_addr_d, x_addr_d;
    logic            rd_bias_q, rd_mac_q;
    logic signed [8:0]    w_sgn;
    logic signed [PW-1:0] prod;

    assign fan_ok = (fan_in != '0) && (32'(fan_in) <= MAX_FANIN);

    // Next state, sequencing counters and the next value of every registered output
    always_comb begin
        state_d     = state;
        n_d         = n_q;
        idx_d       = idx_q;
        err_d       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (fan_ok) begin
                        n_d     = fan_in;
                        idx_d   = '0;
                        state_d = BIAS;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end
            BIAS: begin
                idx_d   = '0;
                state_d = MAC;
            end
            MAC: begin
                if (idx_q == AW'(n_q - AW'(1))) begin
                    state_d = DRAIN;
                end else begin
                    idx_d = AW'(idx_q + AW'(1));
                end
            end
            DRAIN: state_d = OUT;
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d      = (state_d != IDLE);
        out_valid_d = (state_d == OUT);
        mem_rd_d    = (state_d == BIAS) || (state_d == MAC);
        w_addr_d    = (state_d == MAC) ? AW'(idx_d + AW'(1)) : '0;
        x_addr_d    = (state_d == MAC) ? idx_d : '0;
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            n_q       <= '0;
            idx_q     <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
            mem_rd    <= 1'b0;
            w_addr    <= '0;
            x_addr    <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_d;
            n_q       <= n_d;
            idx_q     <= idx_d;
            busy      <= busy_d;
            err       <= err_d;
            mem_rd    <= mem_rd_d;
            w_addr    <= w_addr_d;
            x_addr    <= x_addr_d;
            out_valid <= out_valid_d;
        end
    end

    // Memory data arrives one cycle after the read; tags record what it answers
    assign w_sgn = $signed(w_data);
    assign prod  = PW'(w_sgn) * PW'($signed({1'b0, x_data}));

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_bias_q <= 1'b0;
            rd_mac_q  <= 1'b0;
            result    <= '0;
        end else begin
            rd_bias_q <= (state == BIAS);
            rd_mac_q  <= (state == MAC);
            if (rd_bias_q) begin
                result <= ACC_W'(w_sgn);
            end else if (rd_mac_q) begin
                result <= result + ACC_W'(prod);
            end
        end
    end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed bench for neuron_mac_seq: memory model with one-cycle read latency,
// vector table of hand-computed neurons plus reset and back-pressure sequences.
module tb_neuron_mac_seq;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [8:0]         fan_in;
    logic               busy, err, mem_rd, out_valid, out_ready;
    logic [8:0]         w_addr, x_addr;
    logic [8:0]         w_data;
    logic [7:0]         x_data;
    logic signed [31:0] result;

    int tests = 0;
    int fails = 0;
    int err_cnt = 0;
    int addr_bad = 0;
    logic [17:0] addrq[$];

    logic signed [8:0] wmem [0:511];
    logic [7:0]        xmem [0:511];

    typedef struct {
        string             name;
        int                n;
        logic signed [8:0] bias;
        logic signed [8:0] w0, w1, w2;
        logic [7:0]        x0, x1, x2;
        int                ready_delay;
        bit                spam;
        bit                exp_err;
        int                exp_result;
        int                exp_lat;
    } vec_t;

    vec_t tbl [7];

    neuron_mac_seq dut (
        .clk(clk), .rst(rst), .start(start), .fan_in(fan_in), .busy(busy), .err(err),
        .mem_rd(mem_rd), .w_addr(w_addr), .x_addr(x_addr), .w_data(w_data),
        .x_data(x_data), .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    always #5 clk = ~clk;

    // Memory model: data valid one cycle after the strobe, junk otherwise
    always @(posedge clk) begin
        if (mem_rd) begin
            w_data <= wmem[w_addr];
            x_data <= xmem[x_addr];
        end else begin
            w_data <= 9'h155;
            x_data <= 8'hA5;
        end
    end

    always @(negedge clk) begin
        if (err) err_cnt++;
        if (mem_rd) addrq.push_back({w_addr, x_addr});
        else if (w_addr != 0 || x_addr != 0) addr_bad++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%08h), want %0d (0x%08h)", nm, $signed(act), act,
                     $signed(exp), exp);
        end
    endtask

    task automatic run(input vec_t v);
        int  cyc;
        bit  ok;
        bit  stable;
        for (int k = 0; k < v.n; k++) begin
            wmem[k+1] = (k % 3 == 0) ? v.w0 : (k % 3 == 1) ? v.w1 : v.w2;
            xmem[k]   = (k % 3 == 0) ? v.x0 : (k % 3 == 1) ? v.x1 : v.x2;
        end
        wmem[0] = v.bias;
        @(posedge clk); #1;
        addrq.delete();
        err_cnt = 0;
        addr_bad = 0;
        start = 1'b1;
        fan_in = 9'(v.n);
        out_ready = (v.ready_delay == 0);
        @(posedge clk); #1;
        cyc = 1;
        start = v.spam;
        fan_in = v.spam ? 9'd3 : 9'd0;
        if (v.exp_err) begin
            chk({v.name, " err_pulse"}, 32'(err), 32'd1);
            chk({v.name, " busy_low"}, 32'(busy), 32'd0);
            @(posedge clk); #1;
            chk({v.name, " err_one_cycle"}, 32'(err), 32'd0);
            chk({v.name, " result_kept"}, result, v.exp_result);
            chk({v.name, " err_count"}, err_cnt, 1);
            out_ready = 1'b0;
            return;
        end
        while (!out_valid && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({v.name, " latency"}, cyc, v.exp_lat);
        chk({v.name, " result"}, result, v.exp_result);
        if (v.ready_delay > 0) begin
            stable = 1'b1;
            for (int d = 0; d < v.ready_delay; d++) begin
                if (!out_valid || result !== v.exp_result) stable = 1'b0;
                @(posedge clk); #1;
            end
            chk({v.name, " hold_stable"}, 32'(stable), 32'd1);
            chk({v.name, " still_valid"}, 32'(out_valid), 32'd1);
            out_ready = 1'b1;
            @(posedge clk); #1;
        end else begin
            @(posedge clk); #1;
        end
        start = 1'b0;
        out_ready = 1'b0;
        chk({v.name, " idle_after_hs"}, {30'd0, busy, out_valid}, 32'd0);
        chk({v.name, " result_retained"}, result, v.exp_result);
        @(posedge clk); #1;
        chk({v.name, " stays_idle"}, 32'(busy), 32'd0);
        ok = (addrq.size() == v.n + 1);
        for (int i = 0; ok && i <= v.n; i++) begin
            if (i == 0) ok = (addrq[0] == 18'd0);
            else        ok = (addrq[i] == {9'(i), 9'(i - 1)});
        end
        chk({v.name, " addr_seq"}, 32'(ok), 32'd1);
        chk({v.name, " addr_zero_idle"}, addr_bad, 0);
        chk({v.name, " no_err"}, err_cnt, 0);
    endtask

    initial begin
        tbl[0] = '{"fan3", 3, 9'sd5, 9'sd1, -9'sd2, 9'sd3, 8'd10, 8'd20, 8'd30, 0, 1'b0, 1'b0, 65, 6};
        tbl[1] = '{"fan400", 400, 9'sd0, 9'sd255, 9'sd255, 9'sd255, 8'd255, 8'd255, 8'd255,
                   0, 1'b0, 1'b0, 26010000, 403};
        tbl[2] = '{"fan1_neg", 1, -9'sd256, -9'sd256, 9'sd0, 9'sd0, 8'd255, 8'd0, 8'd0,
                   0, 1'b0, 1'b0, -65536, 4};
        tbl[3] = '{"fan0_err", 0, 9'sd0, 9'sd0, 9'sd0, 9'sd0, 8'd0, 8'd0, 8'd0,
                   0, 1'b0, 1'b1, -65536, 0};
        tbl[4] = '{"fan401_err", 401, 9'sd0, 9'sd0, 9'sd0, 9'sd0, 8'd0, 8'd0, 8'd0,
                   0, 1'b0, 1'b1, -65536, 0};
        tbl[5] = '{"fan6_spam", 6, -9'sd1, 9'sd2, -9'sd3, 9'sd4, 8'd1, 8'd2, 8'd3,
                   0, 1'b1, 1'b0, 15, 9};
        tbl[6] = '{"fan2_hold", 2, 9'sd100, -9'sd256, -9'sd256, 9'sd0, 8'd255, 8'd255, 8'd0,
                   5, 1'b0, 1'b0, -130460, 5};

        rst = 1'b1;
        start = 1'b0;
        fan_in = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", {23'd0, busy, err, mem_rd, out_valid, 5'd0}, 32'd0);
        chk("reset_addr", {14'd0, w_addr, x_addr}, 32'd0);
        chk("reset_result", result, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run(tbl[i]);

        // Reset during MAC k=10 of a 25-input neuron
        for (int k = 0; k < 25; k++) begin
            wmem[k+1] = 9'sd7;
            xmem[k]   = 8'd9;
        end
        wmem[0] = 9'sd1;
        @(posedge clk); #1;
        start = 1'b1;
        fan_in = 9'd25;
        repeat (12) begin
            @(posedge clk); #1;
            start = 1'b0;
            fan_in = '0;
        end
        chk("pre_rst_addr", {14'd0, w_addr, x_addr}, {14'd0, 9'd11, 9'd10});
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_ctrl", {23'd0, busy, err, mem_rd, out_valid, 5'd0}, 32'd0);
        chk("midrst_addr", {14'd0, w_addr, x_addr}, 32'd0);
        chk("midrst_result", result, 32'd0);
        begin
            int seen = 0;
            for (int c = 0; c < 40; c++) begin
                @(posedge clk); #1;
                if (out_valid || busy) seen++;
            end
            chk("midrst_no_valid", seen, 0);
        end
        run(tbl[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running, want finished");
        $fatal(1, "timeout");
    end

endmodule
